// File: rtl/clock_divider_bank_if.sv
// Configuration write channel of clock_divider_bank: valid/ready handshake
// carrying a target channel, a divide ratio and an enable.
interface clock_divider_bank_if #(
  parameter int NUM_CHANNELS = 7,
  parameter int DIV_WIDTH    = 8
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_channel;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_en;

  modport master (
    output cfg_valid,
    output cfg_channel,
    output cfg_div,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_channel,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of independently programmable integer clock dividers. New ratio/enable
// settings are held pending and only applied at a period boundary.
module clock_divider_bank #(
  parameter int NUM_CHANNELS = 7,
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_DIV  = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  clock_divider_bank_if.slave     cfg,
  output logic [NUM_CHANNELS-1:0] clk_out,
  output logic [NUM_CHANNELS-1:0] tick,
  output logic [NUM_CHANNELS-1:0] busy
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_TWO  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH:0]   WIDE_ONE = (DIV_WIDTH+1)'(1);
  localparam logic                 G1_RST   = (DEFAULT_DIV == 1);

  logic [DIV_WIDTH-1:0] div_q  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] div_d  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_q  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_d  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] pdiv_q [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] pdiv_d [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] en_q, en_d;
  logic [NUM_CHANNELS-1:0] pen_q, pen_d;
  logic [NUM_CHANNELS-1:0] busy_q, busy_d;
  logic [NUM_CHANNELS-1:0] oq_q, oq_d;
  logic [NUM_CHANNELS-1:0] tq_q, tq_d;
  logic [NUM_CHANNELS-1:0] g1_q, g1_d;
  logic [NUM_CHANNELS-1:0] sel;
  logic [NUM_CHANNELS-1:0] wrap;
  logic                    cfg_ready_w;
  logic                    accept;

  // Out-of-range channel numbers match nothing, so they stay ready and are dropped.
  always_comb begin
    cfg_ready_w = 1'b1;
    sel         = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cfg.cfg_channel == CH_W'(i)) begin
        sel[i]      = 1'b1;
        cfg_ready_w = !busy_q[i];
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_w;
  assign accept        = cfg.cfg_valid && cfg_ready_w;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    pdiv_d = pdiv_q;
    en_d   = en_q;
    pen_d  = pen_q;
    busy_d = busy_q;
    wrap   = '0;
    oq_d   = '0;
    tq_d   = '0;
    g1_d   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      wrap[i] = (cnt_q[i] == div_q[i] - DIV_ONE);
      if (busy_q[i] && (!en_q[i] || wrap[i])) begin
        div_d[i]  = pdiv_q[i];
        en_d[i]   = pen_q[i];
        cnt_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (en_q[i]) begin
        cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + DIV_ONE;
      end
      if (accept && sel[i]) begin
        pdiv_d[i] = (cfg.cfg_div == '0) ? DIV_ONE : cfg.cfg_div;
        pen_d[i]  = cfg.cfg_en;
        busy_d[i] = 1'b1;
      end
      // High for ceil(n/2) cycles so odd ratios carry the extra cycle high.
      oq_d[i] = en_d[i] && (div_d[i] >= DIV_TWO) &&
                ({1'b0, cnt_d[i]} < (({1'b0, div_d[i]} + WIDE_ONE) >> 1));
      tq_d[i] = en_d[i] && (cnt_d[i] == '0);
      g1_d[i] = en_q[i] && (div_q[i] == DIV_ONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        div_q[i]  <= DEF_DIV;
        cnt_q[i]  <= DEF_DIV - DIV_ONE;
        pdiv_q[i] <= DEF_DIV;
      end
      en_q   <= '1;
      pen_q  <= '1;
      busy_q <= '0;
      oq_q   <= '0;
      tq_q   <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      pdiv_q <= pdiv_d;
      en_q   <= en_d;
      pen_q  <= pen_d;
      busy_q <= busy_d;
      oq_q   <= oq_d;
      tq_q   <= tq_d;
    end
  end

  // Gate for ratio 1: only changes while clock is low, so the AND never chops a pulse.
  always_latch begin
    if (!reset_n) begin
      g1_q <= {NUM_CHANNELS{G1_RST}};
    end else if (!clock) begin
      g1_q <= g1_d;
    end
  end

  assign clk_out = ({NUM_CHANNELS{clock}} & g1_q) | oq_q;
  assign tick    = tq_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed self-checking bench for clock_divider_bank (7 channels, DEFAULT_DIV=1).
// Outputs are sampled 1 time unit after each clock edge: high phase and low phase.
module tb_clock_divider_bank;
  localparam int NCH = 7;
  localparam int DW  = 8;

  logic           clock;
  logic           reset_n;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       valid;
    logic [2:0] ch;
    logic [7:0] div;
    logic       en;
    logic       ready;
    logic [6:0] tick;
    logic [6:0] busy;
    logic [6:0] hi;
    logic [6:0] lo;
  } vec_t;

  vec_t vecs[$];
  vec_t post_vecs[$];

  clock_divider_bank_if #(.NUM_CHANNELS(NCH), .DIV_WIDTH(DW)) cfg_if ();

  clock_divider_bank #(
    .NUM_CHANNELS(NCH),
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .cfg    (cfg_if),
    .clk_out(clk_out),
    .tick   (tick),
    .busy   (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] ch, input logic [7:0] d, input logic e);
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_channel = ch;
    cfg_if.cfg_div     = d;
    cfg_if.cfg_en      = e;
    #1;
  endtask

  task automatic runCycle(output logic [6:0] hi, output logic [6:0] lo,
                          output logic [6:0] tk, output logic [6:0] bs);
    @(posedge clock);
    #1;
    hi = clk_out;
    tk = tick;
    bs = busy;
    @(negedge clock);
    #1;
    lo = clk_out;
  endtask

  task automatic applyVec(input string name, input vec_t v);
    logic [6:0] hi, lo, tk, bs;
    applyStimulus(v.valid, v.ch, v.div, v.en);
    checkOutput($sformatf("%s.ready", name), {7'b0, cfg_if.cfg_ready}, {7'b0, v.ready});
    runCycle(hi, lo, tk, bs);
    checkOutput($sformatf("%s.tick", name), {1'b0, tk}, {1'b0, v.tick});
    checkOutput($sformatf("%s.busy", name), {1'b0, bs}, {1'b0, v.busy});
    checkOutput($sformatf("%s.clk_hi", name), {1'b0, hi}, {1'b0, v.hi});
    checkOutput($sformatf("%s.clk_lo", name), {1'b0, lo}, {1'b0, v.lo});
  endtask

  // One cycle of a hand-written sequence, checking a single watched channel.
  task automatic seqStep(input string name, input logic v, input logic [2:0] ch,
                         input logic [7:0] d, input logic e, input int w,
                         input logic er, input logic eb, input logic elo,
                         input logic ehi, input logic etk);
    logic [6:0] hi, lo, tk, bs;
    applyStimulus(v, ch, d, e);
    checkOutput($sformatf("%s.ready", name), {7'b0, cfg_if.cfg_ready}, {7'b0, er});
    runCycle(hi, lo, tk, bs);
    checkOutput($sformatf("%s.busy", name), {7'b0, bs[w]}, {7'b0, eb});
    checkOutput($sformatf("%s.clk_lo", name), {7'b0, lo[w]}, {7'b0, elo});
    checkOutput($sformatf("%s.clk_hi", name), {7'b0, hi[w]}, {7'b0, ehi});
    checkOutput($sformatf("%s.tick", name), {7'b0, tk[w]}, {7'b0, etk});
  endtask

  initial begin
    reset_n            = 1'b0;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_channel = 3'd0;
    cfg_if.cfg_div     = 8'd0;
    cfg_if.cfg_en      = 1'b0;

    // Reset window: ratio-1 gate is open, so clk_out follows clock.
    @(negedge clock);
    #1;
    checkOutput("rst.clk_lo", {1'b0, clk_out}, 8'h00);
    checkOutput("rst.tick", {1'b0, tick}, 8'h00);
    checkOutput("rst.busy", {1'b0, busy}, 8'h00);
    checkOutput("rst.ready", {7'b0, cfg_if.cfg_ready}, 8'h01);
    @(posedge clock);
    #1;
    checkOutput("rst.clk_hi", {1'b0, clk_out}, 8'h7F);
    checkOutput("rst.tick_hi", {1'b0, tick}, 8'h00);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // Release, then channel 2 retuned to divide-by-4.
    vecs.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h00});
    vecs.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h00});
    vecs.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h00});
    vecs.push_back('{1'b1, 3'd2, 8'd4, 1'b1, 1'b1, 7'h7F, 7'h04, 7'h7F, 7'h00});
    vecs.push_back('{1'b0, 3'd2, 8'd0, 1'b0, 1'b0, 7'h7F, 7'h00, 7'h7F, 7'h04});
    vecs.push_back('{1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 7'h7B, 7'h00, 7'h7F, 7'h04});
    vecs.push_back('{1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 7'h7B, 7'h00, 7'h7B, 7'h00});
    vecs.push_back('{1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 7'h7B, 7'h00, 7'h7B, 7'h00});
    vecs.push_back('{1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h04});
    vecs.push_back('{1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 7'h7B, 7'h00, 7'h7F, 7'h04});
    for (int i = 0; i < vecs.size(); i++) begin
      applyVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Channel 3: div 5, retune to 2 mid-period, then a stalled write of div 0.
    seqStep("C1",  1'b1, 3'd3, 8'd5, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    seqStep("C2",  1'b0, 3'd3, 8'd0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    seqStep("C3",  1'b0, 3'd3, 8'd0, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    seqStep("C4",  1'b1, 3'd3, 8'd2, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    seqStep("D5",  1'b1, 3'd3, 8'd0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    seqStep("D6",  1'b1, 3'd3, 8'd0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    seqStep("D7",  1'b1, 3'd3, 8'd0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    seqStep("D8",  1'b1, 3'd3, 8'd0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    seqStep("D9",  1'b0, 3'd3, 8'd0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    seqStep("D10", 1'b0, 3'd3, 8'd0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Channel 0: divide-by-3, disable at the boundary, then re-enable.
    seqStep("E1",  1'b1, 3'd0, 8'd3, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    seqStep("E2",  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    seqStep("E3",  1'b1, 3'd0, 8'd3, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    seqStep("E4",  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    seqStep("E5",  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seqStep("E6",  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seqStep("E7",  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seqStep("E8",  1'b1, 3'd0, 8'd3, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    seqStep("E9",  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    seqStep("E10", 1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    seqStep("E11", 1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Out-of-range channel, then two pending writes lost to a mid-period reset.
    seqStep("F1",  1'b1, 3'd7, 8'd5, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("F1.busy_all", {1'b0, busy}, 8'h00);
    seqStep("F2",  1'b1, 3'd0, 8'd7, 1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    seqStep("F3",  1'b1, 3'd4, 8'd5, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("F3.busy_all", {1'b0, busy}, 8'h11);

    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("mrst.busy", {1'b0, busy}, 8'h00);
    checkOutput("mrst.tick", {1'b0, tick}, 8'h00);
    checkOutput("mrst.clk_lo", {1'b0, clk_out}, 8'h00);
    checkOutput("mrst.ready", {7'b0, cfg_if.cfg_ready}, 8'h01);
    @(posedge clock);
    #1;
    checkOutput("mrst.clk_hi", {1'b0, clk_out}, 8'h7F);
    checkOutput("mrst.tick_hi", {1'b0, tick}, 8'h00);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    post_vecs.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h00});
    post_vecs.push_back('{1'b0, 3'd4, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h00});
    post_vecs.push_back('{1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 7'h7F, 7'h00, 7'h7F, 7'h00});
    for (int i = 0; i < post_vecs.size(); i++) begin
      applyVec($sformatf("post%0d", i), post_vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
